player_physics: RTL and testbench

PLAYER_PHYSICS -- requirements
Module: player_physics

---
 rtl/player_physics_if.sv | 37 +++
 rtl/player_physics.sv | 174 +++++++++++++++++
 tb/tb_player_physics.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/player_physics_if.sv
`default_nettype none
// ============================================================================
// Module    : player_physics_if
// Purpose   : Groups the player-physics control and status signals.
//             The master side (game logic / bench) drives the step strobe,
//             flip request, freeze and ground-line map. The slave side
//             (player_physics) returns the position, speed and status.
// Ports     : tick, flip_req, is_dead, lines[N_LINES]  master -> slave
//             height[Y_W], vel[4], grav_dir,
//             on_ground, fell_off                       slave -> master
// Revision  : 1.0 - initial release
// ============================================================================
interface player_physics_if #(
  parameter int N_LINES = 3,
  parameter int Y_W     = 9
);
  logic               tick;
  logic               flip_req;
  logic               is_dead;
  logic [N_LINES-1:0] lines;
  logic [Y_W-1:0]     height;
  logic [3:0]         vel;
  logic               grav_dir;
  logic               on_ground;
  logic               fell_off;

  modport master (
    output tick, flip_req, is_dead, lines,
    input  height, vel, grav_dir, on_ground, fell_off
  );

  modport slave (
    input  tick, flip_req, is_dead, lines,
    output height, vel, grav_dir, on_ground, fell_off
  );
endinterface
`default_nettype wire

// File: rtl/player_physics.sv
`default_nettype none
// ============================================================================
// Module    : player_physics
// Purpose   : Vertical motion of a runner that stands on horizontal ground
//             lines and can flip gravity. Three states: RUN (grounded),
//             AIR (moving), OUT (left the screen; held until reset).
// Ports     : clk    - clock, all state changes on the rising edge
//             reset  - synchronous active-high reset
//             bus    - player_physics_if.slave (step strobe, flip request,
//                      freeze, line map in; height/vel/gravity/status out)
// Revision  : 1.0 - initial release
// ============================================================================
module player_physics #(
  parameter int N_LINES    = 3,
  parameter int Y_W        = 9,
  parameter int LINE_Y0    = 120,
  parameter int LINE_PITCH = 120,
  parameter int PLAYER_H   = 60,
  parameter int SCREEN_H   = 480,
  parameter int V_MAX      = 4,
  parameter int START_LINE = 1
) (
  input  logic                clk,
  input  logic                reset,
  player_physics_if.slave     bus
);

  // One extra bit so a step past the top of the screen is seen as negative.
  typedef logic signed [Y_W:0] ys_t;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_AIR = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  localparam ys_t            H_MAX   = ys_t'(SCREEN_H - PLAYER_H);
  localparam logic [Y_W-1:0] H_RESET = Y_W'(LINE_Y0 + START_LINE * LINE_PITCH - PLAYER_H);
  localparam logic [3:0]     VEL_MAX = 4'(V_MAX);

  // Landing y for line k: the sprite rests on top of the line when falling
  // down and hangs below it (top-left corner on the line) when falling up.
  function automatic ys_t land_y(input int k, input logic up);
    return ys_t'(LINE_Y0 + k * LINE_PITCH - (up ? 0 : PLAYER_H));
  endfunction

  state_t         state_q, state_d;
  logic [Y_W-1:0] height_q, height_d;
  logic [3:0]     vel_q, vel_d;
  logic           grav_q, grav_d;
  logic           fell_q, fell_d;

  ys_t            h_cur;
  ys_t            h_new;
  ys_t            step;
  ys_t            snap_y;
  ys_t            p;
  logic [3:0]     vel_n;
  logic           grounded;
  logic           snap_hit;
  logic           crossed;
  logic           do_air;

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    vel_d    = vel_q;
    grav_d   = grav_q;
    fell_d   = fell_q;
    do_air   = 1'b0;
    grounded = 1'b0;
    snap_hit = 1'b0;
    snap_y   = '0;
    p        = '0;
    crossed  = 1'b0;

    h_cur = ys_t'({1'b0, height_q});
    vel_n = (vel_q >= VEL_MAX) ? VEL_MAX : vel_q + 4'd1;
    step  = ys_t'({{(Y_W-3){1'b0}}, vel_n});
    h_new = grav_q ? (h_cur - step) : (h_cur + step);

    for (int k = 0; k < N_LINES; k++) begin
      if (bus.lines[k] && (land_y(k, grav_q) == h_cur)) begin
        grounded = 1'b1;
      end
    end

    // Nearest present landing crossed or reached by this step; the
    // comparison against the current best keeps the result independent of
    // line ordering.
    for (int k = 0; k < N_LINES; k++) begin
      p       = land_y(k, grav_q);
      crossed = grav_q ? ((h_new <= p) && (p < h_cur))
                       : ((h_cur < p) && (p <= h_new));
      if (bus.lines[k] && crossed &&
          (!snap_hit || (grav_q ? (p > snap_y) : (p < snap_y)))) begin
        snap_hit = 1'b1;
        snap_y   = p;
      end
    end

    if (!bus.is_dead) begin
      case (state_q)
        ST_RUN: begin
          // A flip starts the motion from rest; any tick in the same cycle
          // is absorbed so the first move happens on the next tick.
          if (bus.flip_req) begin
            grav_d  = ~grav_q;
            vel_d   = 4'd0;
            state_d = ST_AIR;
          end else if (bus.tick) begin
            if (grounded) begin
              vel_d = 4'd0;
            end else begin
              do_air = 1'b1;
            end
          end
        end
        ST_AIR: begin
          if (bus.tick) begin
            do_air = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (do_air) begin
      if (snap_hit) begin
        height_d = snap_y[Y_W-1:0];
        vel_d    = 4'd0;
        state_d  = ST_RUN;
      end else if (h_new < ys_t'(0)) begin
        height_d = '0;
        vel_d    = 4'd0;
        fell_d   = 1'b1;
        state_d  = ST_OUT;
      end else if (h_new > H_MAX) begin
        height_d = H_MAX[Y_W-1:0];
        vel_d    = 4'd0;
        fell_d   = 1'b1;
        state_d  = ST_OUT;
      end else begin
        height_d = h_new[Y_W-1:0];
        vel_d    = vel_n;
        state_d  = ST_AIR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      height_q <= H_RESET;
      vel_q    <= 4'd0;
      grav_q   <= 1'b0;
      fell_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      height_q <= height_d;
      vel_q    <= vel_d;
      grav_q   <= grav_d;
      fell_q   <= fell_d;
    end
  end

  assign bus.height    = height_q;
  assign bus.vel       = vel_q;
  assign bus.grav_dir  = grav_q;
  assign bus.on_ground = (state_q == ST_RUN);
  assign bus.fell_off  = fell_q;

endmodule
`default_nettype wire

// File: tb/tb_player_physics.sv
`default_nettype none
// ============================================================================
// Module    : tb_player_physics
// Purpose   : Self-checking bench for player_physics. A table of single-step
//             vectors plus hand-written fall/flip/off-screen sequences; each
//             step pushes its expected outputs to a scoreboard queue and the
//             entry is popped and compared after the clock edge.
// Ports     : none
// Revision  : 1.0 - initial release
// ============================================================================
module tb_player_physics;

  typedef struct packed {
    logic [8:0] h;
    logic [3:0] v;
    logic       g;
    logic       og;
    logic       fo;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic       t;
    logic       f;
    logic       d;
    logic [2:0] ln;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t tbl[19];

  player_physics_if #(.N_LINES(3), .Y_W(9)) bus ();

  player_physics dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int h, input int v, input logic g,
                              input logic og, input logic fo);
    exp_t e;
    e.h  = 9'(h);
    e.v  = 4'(v);
    e.g  = g;
    e.og = og;
    e.fo = fo;
    return e;
  endfunction

  function automatic vec_t mkv(input logic r, input logic t, input logic f,
                               input logic d, input logic [2:0] ln, input exp_t e);
    vec_t x;
    x.r  = r;
    x.t  = t;
    x.f  = f;
    x.d  = d;
    x.ln = ln;
    x.e  = e;
    return x;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then compare the popped
  // expectation against the registered outputs.
  task automatic step(input string name, input logic r, input logic t,
                      input logic f, input logic d, input logic [2:0] ln,
                      input exp_t e);
    exp_t want;
    exp_t got;
    sb_q.push_back(e);
    reset        = r;
    bus.tick     = t;
    bus.flip_req = f;
    bus.is_dead  = d;
    bus.lines    = ln;
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    got  = {bus.height, bus.vel, bus.grav_dir, bus.on_ground, bus.fell_off};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got h=%0d v=%0d g=%0d og=%0d fo=%0d, want h=%0d v=%0d g=%0d og=%0d fo=%0d",
               name, got.h, got.v, got.g, got.og, got.fo,
               want.h, want.v, want.g, want.og, want.fo);
    end
  endtask

  initial begin
    int  h;
    int  v;
    int  nh;
    bit  done;

    reset        = 1'b1;
    bus.tick     = 1'b0;
    bus.flip_req = 1'b0;
    bus.is_dead  = 1'b0;
    bus.lines    = 3'b000;

    //          r  t  f  d  lines          h    v  g  og fo
    tbl[0]  = mkv(1, 0, 0, 0, 3'b010, mk(180, 0, 0, 1, 0)); // reset state
    tbl[1]  = mkv(0, 1, 0, 0, 3'b010, mk(180, 0, 0, 1, 0)); // grounded tick
    tbl[2]  = mkv(0, 0, 0, 0, 3'b000, mk(180, 0, 0, 1, 0)); // no tick, no line
    tbl[3]  = mkv(0, 1, 0, 0, 3'b100, mk(181, 1, 0, 0, 0)); // walk off
    tbl[4]  = mkv(0, 1, 1, 0, 3'b100, mk(183, 2, 0, 0, 0)); // flip in AIR ignored
    tbl[5]  = mkv(0, 0, 1, 0, 3'b100, mk(183, 2, 0, 0, 0)); // flip only, AIR
    tbl[6]  = mkv(0, 1, 0, 0, 3'b100, mk(186, 3, 0, 0, 0));
    tbl[7]  = mkv(0, 1, 0, 1, 3'b100, mk(186, 3, 0, 0, 0)); // frozen
    tbl[8]  = mkv(0, 1, 1, 1, 3'b100, mk(186, 3, 0, 0, 0));
    tbl[9]  = mkv(0, 1, 0, 1, 3'b100, mk(186, 3, 0, 0, 0));
    tbl[10] = mkv(0, 1, 0, 1, 3'b100, mk(186, 3, 0, 0, 0));
    tbl[11] = mkv(0, 1, 0, 1, 3'b100, mk(186, 3, 0, 0, 0));
    tbl[12] = mkv(0, 1, 0, 0, 3'b100, mk(190, 4, 0, 0, 0)); // resumes
    tbl[13] = mkv(0, 1, 0, 0, 3'b100, mk(194, 4, 0, 0, 0)); // capped at 4
    tbl[14] = mkv(1, 1, 0, 0, 3'b100, mk(180, 0, 0, 1, 0)); // reset mid-fall
    tbl[15] = mkv(0, 0, 1, 0, 3'b010, mk(180, 0, 1, 0, 0)); // flip in RUN
    tbl[16] = mkv(0, 1, 0, 0, 3'b010, mk(179, 1, 1, 0, 0)); // rising
    tbl[17] = mkv(1, 0, 0, 0, 3'b010, mk(180, 0, 0, 1, 0));
    tbl[18] = mkv(0, 1, 1, 1, 3'b010, mk(180, 0, 0, 1, 0)); // dead blocks flip

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tbl[i].r, tbl[i].t, tbl[i].f, tbl[i].d,
           tbl[i].ln, tbl[i].e);
    end

    // Standing on line 1 for 10 ticks.
    step("stand_rst", 1, 0, 0, 0, 3'b010, mk(180, 0, 0, 1, 0));
    for (int i = 0; i < 10; i++) begin
      step("stand", 0, 1, 0, 0, 3'b010, mk(180, 0, 0, 1, 0));
    end

    // Fall from line 1 onto line 2 (landing y 300).
    step("fall_rst", 1, 0, 0, 0, 3'b100, mk(180, 0, 0, 1, 0));
    h = 180; v = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      v  = (v < 4) ? v + 1 : 4;
      nh = h + v;
      if (nh >= 300) begin
        step("fall_land", 0, 1, 0, 0, 3'b100, mk(300, 0, 0, 1, 0));
        done = 1;
      end else begin
        step("fall", 0, 1, 0, 0, 3'b100, mk(nh, v, 0, 0, 0));
        h = nh;
      end
    end
    step("fall_hold", 0, 1, 0, 0, 3'b100, mk(300, 0, 0, 1, 0));

    // Flip with a simultaneous tick, then rise onto line 0 (landing y 120).
    step("up_rst", 1, 0, 0, 0, 3'b011, mk(180, 0, 0, 1, 0));
    step("up_flip", 0, 1, 1, 0, 3'b011, mk(180, 0, 1, 0, 0));
    h = 180; v = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      v  = (v < 4) ? v + 1 : 4;
      nh = h - v;
      if (nh <= 120) begin
        step("up_land", 0, 1, 0, 0, 3'b011, mk(120, 0, 1, 1, 0));
        done = 1;
      end else begin
        step("up", 0, 1, 0, 0, 3'b011, mk(nh, v, 1, 0, 0));
        h = nh;
      end
    end
    step("up_hold", 0, 1, 0, 0, 3'b011, mk(120, 0, 1, 1, 0));

    // No ground at all: clamp at the bottom and stay out until reset.
    step("out_rst", 1, 0, 0, 0, 3'b000, mk(180, 0, 0, 1, 0));
    h = 180; v = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      v  = (v < 4) ? v + 1 : 4;
      nh = h + v;
      if (nh > 420) begin
        step("out_clamp", 0, 1, 0, 0, 3'b000, mk(420, 0, 0, 0, 1));
        done = 1;
      end else begin
        step("out_fall", 0, 1, 0, 0, 3'b000, mk(nh, v, 0, 0, 0));
        h = nh;
      end
    end
    step("out_tick", 0, 1, 0, 0, 3'b111, mk(420, 0, 0, 0, 1));
    step("out_flip", 0, 1, 1, 0, 3'b111, mk(420, 0, 0, 0, 1));
    step("out_flip2", 0, 0, 1, 0, 3'b000, mk(420, 0, 0, 0, 1));
    step("out_reset", 1, 0, 0, 0, 3'b000, mk(180, 0, 0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
